// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file controller.
//   - Default register width and register count.
//   - FSM state encoding (2 bits).
package regfile_ctrl_pkg;

  localparam int REGCTRL_DATA_WIDTH   = 32;
  localparam int REGCTRL_NUM_REGISTER = 32;

  typedef enum logic [1:0] {
    REGCTRL_INIT    = 2'd0,
    REGCTRL_RUN     = 2'd1,
    REGCTRL_DBG     = 2'd2,
    REGCTRL_DBG_ACK = 2'd3
  } regctrl_state_e;

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset clear sequencer.
// It walks the register addresses 1..NUM_REGISTER-1, one address per cycle.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset; restarts the walk at address 1
//   o_addr   address being cleared this cycle
//   o_last   this cycle clears the final register
//   o_done   walk finished; stays set until reset
module regfile_init_seq #(
  parameter  int NUM_REGISTER = 32,
  localparam int ADDR_W       = $clog2(NUM_REGISTER)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGISTER - 1);

  logic [ADDR_W-1:0] cnt;
  logic              done;

  // x0 is hardwired, so the walk starts at 1.
  // The counter freezes once the walk completes.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt  <= ADDR_W'(1);
      done <= 1'b0;
    end else if (!done) begin
      if (cnt == LAST_ADDR) begin
        done <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_addr = cnt;
  assign o_last = (cnt == LAST_ADDR) && !done;
  assign o_done = done;

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file controller.
// After reset it clears x1..x(N-1) while stalling the core.
// It then time-shares the register file's write port and rs1 read port
// between the core and a debug requester.
// Ports:
//   i_clk, i_rst_n                       clock, synchronous active-low reset
//   i_core_we/_rd_addr/_rd               core writeback
//   i_core_rs1_addr/_rs2_addr            core read addresses
//   o_core_stall                         core holds PC and drops writeback
//   i_dbg_req/_we/_addr/_wdata           debug access, held until o_dbg_ack
//   o_dbg_ack                            one-cycle completion pulse
//   o_dbg_rdata                          registered read result, valid from ack
//   o_init_done                          clear finished (sticky)
//   o_rf_*                               drive register_file inputs
//   i_rf_rs1                             register_file rs1 read data
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter  int DATA_WIDTH   = REGCTRL_DATA_WIDTH,
  parameter  int NUM_REGISTER = REGCTRL_NUM_REGISTER,
  localparam int ADDR_W       = $clog2(NUM_REGISTER)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_core_we,
  input  logic [ADDR_W-1:0]     i_core_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_core_rd,
  input  logic [ADDR_W-1:0]     i_core_rs1_addr,
  input  logic [ADDR_W-1:0]     i_core_rs2_addr,
  output logic                  o_core_stall,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [ADDR_W-1:0]     i_dbg_addr,
  input  logic [DATA_WIDTH-1:0] i_dbg_wdata,
  output logic                  o_dbg_ack,
  output logic [DATA_WIDTH-1:0] o_dbg_rdata,
  output logic                  o_init_done,
  output logic                  o_rf_we,
  output logic [ADDR_W-1:0]     o_rf_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rf_rd,
  output logic [ADDR_W-1:0]     o_rf_rs1_addr,
  output logic [ADDR_W-1:0]     o_rf_rs2_addr,
  input  logic [DATA_WIDTH-1:0] i_rf_rs1
);

  regctrl_state_e        state;
  logic [DATA_WIDTH-1:0] dbg_rdata_q;
  logic [ADDR_W-1:0]     seq_addr;
  logic                  seq_last;
  logic                  seq_done;

  regfile_init_seq #(
    .NUM_REGISTER (NUM_REGISTER)
  ) u_init_seq (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_addr  (seq_addr),
    .o_last  (seq_last),
    .o_done  (seq_done)
  );

  // The sequencer resets together with the FSM.
  // Its last cycle therefore coincides with the INIT -> RUN transition.
  // Reset in DBG simply drops the access, so no ack is ever issued for it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= REGCTRL_INIT;
      dbg_rdata_q <= '0;
    end else begin
      case (state)
        REGCTRL_INIT: begin
          if (seq_last) state <= REGCTRL_RUN;
        end
        REGCTRL_RUN: begin
          if (i_dbg_req) state <= REGCTRL_DBG;
        end
        REGCTRL_DBG: begin
          // rs1 carries the debug address here.
          // For a write, this captures the value from before the write.
          dbg_rdata_q <= i_rf_rs1;
          state       <= REGCTRL_DBG_ACK;
        end
        REGCTRL_DBG_ACK: begin
          // The request is still held during ack, so it is ignored here.
          // This guarantees the core gets this cycle plus at least one RUN cycle.
          state <= REGCTRL_RUN;
        end
        default: state <= REGCTRL_INIT;
      endcase
    end
  end

  always_comb begin
    o_rf_we       = 1'b0;
    o_rf_rd_addr  = i_core_rd_addr;
    o_rf_rd       = i_core_rd;
    o_rf_rs1_addr = i_core_rs1_addr;
    o_rf_rs2_addr = i_core_rs2_addr;
    o_core_stall  = 1'b0;
    o_dbg_ack     = 1'b0;
    case (state)
      REGCTRL_INIT: begin
        o_rf_we      = 1'b1;
        o_rf_rd_addr = seq_addr;
        o_rf_rd      = '0;
        o_core_stall = 1'b1;
      end
      REGCTRL_RUN: begin
        o_rf_we = i_core_we && (i_core_rd_addr != '0);
      end
      REGCTRL_DBG: begin
        // The core's writeback is dropped; it re-executes after the stall.
        o_core_stall  = 1'b1;
        o_rf_rs1_addr = i_dbg_addr;
        o_rf_rd_addr  = i_dbg_addr;
        o_rf_rd       = i_dbg_wdata;
        o_rf_we       = i_dbg_we && (i_dbg_addr != '0);
      end
      REGCTRL_DBG_ACK: begin
        o_dbg_ack = 1'b1;
        o_rf_we   = i_core_we && (i_core_rd_addr != '0);
      end
      default: ;
    endcase
  end

  assign o_dbg_rdata = dbg_rdata_q;
  assign o_init_done = seq_done;

endmodule

// File: tb/tb_regfile_ctrl.sv
module tb_regfile_ctrl;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_we;
  logic [AW-1:0] core_rd_addr;
  logic [DW-1:0] core_rd;
  logic [AW-1:0] core_rs1, core_rs2;
  logic          stall;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          done;
  logic          rf_we;
  logic [AW-1:0] rf_rd_addr, rf_rs1_addr, rf_rs2_addr;
  logic [DW-1:0] rf_rd, rf_rs1;

  always #5 clk = ~clk;

  regfile_ctrl #(.DATA_WIDTH(DW), .NUM_REGISTER(NR)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_core_we(core_we), .i_core_rd_addr(core_rd_addr), .i_core_rd(core_rd),
    .i_core_rs1_addr(core_rs1), .i_core_rs2_addr(core_rs2),
    .o_core_stall(stall),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_ack(ack), .o_dbg_rdata(rdata), .o_init_done(done),
    .o_rf_we(rf_we), .o_rf_rd_addr(rf_rd_addr), .o_rf_rd(rf_rd),
    .o_rf_rs1_addr(rf_rs1_addr), .o_rf_rs2_addr(rf_rs2_addr),
    .i_rf_rs1(rf_rs1)
  );

  // Behavioural register file.
  // x0 is not protected here, so a stray x0 write would be visible.
  // preload fills x1..x31 with nonzero junk so that the clear is observable.
  logic [DW-1:0] rf [NR];
  logic          preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NR; i++) rf[i] <= (i == 0) ? '0 : (32'hA5A5_0000 | 32'(i));
    end else if (rf_we) begin
      rf[rf_rd_addr] <= rf_rd;
    end
  end
  assign rf_rs1 = rf[rf_rs1_addr];

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: every ack must match the oldest expected read result.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("ack_without_request", 64'(ack), 64'd0);
      end else begin
        automatic logic [DW-1:0] e = exp_q.pop_front();
        check("dbg_rdata_at_ack", 64'(rdata), 64'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at the negedge of the first INIT cycle.
  // Returns at the negedge of the first RUN cycle.
  // req_at > 0 raises a read of x3 when the counter reaches req_at+1.
  task automatic init_walk(input int req_at);
    for (int k = 1; k < NR; k++) begin
      check($sformatf("init_cycle_%0d", k), {rf_we, rf_rd_addr, rf_rd, stall, done},
            {1'b1, AW'(k), 32'h0, 1'b1, 1'b0});
      tick();
      if (k == req_at) begin
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
        exp_q.push_back(32'h0);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    automatic logic [5:0] b2b_stall = 6'b010010;
    preload = 1'b1; rst_n = 1'b0;
    core_we = 1'b0; core_rd_addr = '0; core_rd = '0; core_rs1 = '0; core_rs2 = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    // Reset held for two edges, then the clear walk.
    tick(); preload = 1'b0;
    tick(); rst_n = 1'b1;
    @(negedge clk);
    check("rst_ack", 64'(ack), 0);
    check("rst_stall", 64'(stall), 1);
    check("rst_done", 64'(done), 0);
    check("rst_rdata", 64'(rdata), 0);
    init_walk(0);
    check("init_done_high", 64'(done), 1);
    check("run_no_stall", 64'(stall), 0);
    for (int i = 0; i < NR; i++) begin
      core_rs1 = AW'(i);
      @(negedge clk);
      check($sformatf("cleared_x%0d", i), 64'(rf_rs1), 0);
    end

    // Debug write of x5, then debug read of x5.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'hDEAD_BEEF;
    exp_q.push_back(32'h0);
    tick(); @(negedge clk);
    check("dbgw_stall", 64'(stall), 1);
    check("dbgw_ports", {rf_we, rf_rd_addr, rf_rd, rf_rs1_addr}, {1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5});
    tick(); dbg_req = 1'b0; core_rs1 = 5'd5; @(negedge clk);
    check("dbgw_ack_stall", 64'(stall), 0);
    check("dbgw_visible_to_core", 64'(rf_rs1), 64'h0000_0000_DEAD_BEEF);
    tick(); @(negedge clk);
    check("ack_single_cycle", 64'(ack), 0);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
    exp_q.push_back(32'hDEAD_BEEF);
    tick(); @(negedge clk);
    check("dbgr_stall", 64'(stall), 1);
    check("dbgr_no_write", 64'(rf_we), 0);
    tick(); dbg_req = 1'b0; @(negedge clk);
    check("dbgr_ack_stall", 64'(stall), 0);
    tick(); @(negedge clk);

    // x0 protection for the core and for debug.
    core_we = 1'b1; core_rd_addr = 5'd0; core_rd = 32'hFFFF_FFFF;
    #1 check("core_x0_we", 64'(rf_we), 0);
    tick(); core_we = 1'b0; core_rs1 = 5'd0; @(negedge clk);
    check("core_x0_reads_0", 64'(rf_rs1), 0);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'h1234_5678;
    exp_q.push_back(32'h0);
    tick(); @(negedge clk);
    check("dbg_x0_we", 64'(rf_we), 0);
    tick(); dbg_req = 1'b0; @(negedge clk);
    check("dbg_x0_reads_0", 64'(rf_rs1), 0);
    tick(); @(negedge clk);

    // Request held continuously.
    // States are RUN, DBG, ACK, RUN, DBG, ACK.
    // A core write of x7 is presented from the DBG cycle onward.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("b2b_stall_%0d", c), 64'(stall), 64'(b2b_stall[c]));
      if (c == 1) check("b2b_core_wb_suppressed", 64'(rf_we), 0);
      if (c == 2) check("b2b_core_wb_in_ack", {rf_we, rf_rd_addr, rf_rd}, {1'b1, 5'd7, 32'h7});
      tick();
      if (c == 0) begin core_we = 1'b1; core_rd_addr = 5'd7; core_rd = 32'h7; end
      if (c == 2) core_we = 1'b0;
      if (c == 4) dbg_req = 1'b0;
      @(negedge clk);
    end
    core_rs1 = 5'd7;
    #1 check("b2b_x7_written", 64'(rf_rs1), 64'h7);
    check("rdata_held_after_ack", 64'(rdata), 64'h0000_0000_DEAD_BEEF);
    @(negedge clk);

    // Reset while in DBG aborts the access.
    // The clear then restarts, and a read of x3 is raised mid-clear.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'h9999_9999;
    tick(); @(negedge clk);
    check("abort_in_dbg", 64'(stall), 1);
    rst_n = 1'b0; dbg_req = 1'b0; preload = 1'b1;
    tick(); preload = 1'b0; rst_n = 1'b1; @(negedge clk);
    check("abort_no_ack", 64'(ack), 0);
    check("abort_rdata_cleared", 64'(rdata), 0);
    check("abort_stall", 64'(stall), 1);
    check("abort_done_cleared", 64'(done), 0);
    init_walk(4);
    check("reinit_done", 64'(done), 1);
    check("pending_req_run_first", 64'(stall), 0);
    tick(); @(negedge clk);
    check("pending_req_dbg", {stall, rf_rs1_addr}, {1'b1, 5'd3});
    tick(); dbg_req = 1'b0; @(negedge clk);
    tick(); @(negedge clk);

    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
